// File: rtl/pxs_ball_finder.sv
// Per-frame ball locator on the 26-bit RGB pixel tap; stream forwarded with one cycle of delay.
// Define PXS_BALL_FINDER_CENTER_EN to report the bounding-box centre instead of the min-1 corner.
`ifndef VGA
`define VGA 25:23
`endif
`ifndef XC
`define XC 22:13
`endif
`ifndef YC
`define YC 12:3
`endif
`ifndef RGB
`define RGB 2:0
`endif

module pxs_ball_finder #(
  parameter logic [2:0] MATCH_RGB  = 3'b111,
  parameter int         MIN_PIXELS = 4,
  parameter int         H_ACTIVE   = 640,
  parameter int         V_ACTIVE   = 480
) (
  input  logic        px_clk,
  input  logic        rst_n,
  input  logic [25:0] RGBStr_i,
  output logic [25:0] RGBStr_o,
  output logic [9:0]  x_ball,
  output logic [9:0]  y_ball,
  output logic        found,
  output logic        frame_done
);

  typedef enum logic [1:0] {SYNC = 2'd0, SCAN = 2'd1, COMMIT = 2'd2} state_t;

  localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);
  localparam logic [18:0] MIN_LIM = 19'(MIN_PIXELS);
  localparam logic [18:0] CNT_MAX = {19{1'b1}};
  localparam logic [9:0]  MIN_CLR = 10'h3FF;

  function automatic logic [9:0] lower(input logic [9:0] a, input logic [9:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [18:0] sat_inc(input logic [18:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + 19'd1;
  endfunction

`ifdef PXS_BALL_FINDER_CENTER_EN
  localparam logic [9:0] MAX_CLR = 10'h000;

  function automatic logic [9:0] upper(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? a : b;
  endfunction

  // Sum kept in 11 bits so the halved result never wraps.
  function automatic logic [9:0] ball_coord(input logic [9:0] lo, input logic [9:0] hi);
    logic [10:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[10:1];
  endfunction
`else
  function automatic logic [9:0] ball_coord(input logic [9:0] lo);
    return (lo == 10'd0) ? 10'd0 : lo - 10'd1;
  endfunction
`endif

  state_t      state_q, state_d;
  logic [25:0] rgbstr_q;
  logic [9:0]  prev_yc_q;
  logic [9:0]  min_x_q, min_x_d, min_y_q, min_y_d;
  logic [18:0] cnt_q, cnt_d;
  logic [9:0]  snap_min_x_q, snap_min_x_d, snap_min_y_q, snap_min_y_d;
  logic [18:0] snap_cnt_q, snap_cnt_d;
  logic [9:0]  x_ball_q, x_ball_d, y_ball_q, y_ball_d;
  logic        found_q, found_d, frame_done_q, frame_done_d;
`ifdef PXS_BALL_FINDER_CENTER_EN
  logic [9:0]  max_x_q, max_x_d, max_y_q, max_y_d;
  logic [9:0]  snap_max_x_q, snap_max_x_d, snap_max_y_q, snap_max_y_d;
`endif

  logic [9:0] x_in_s, y_in_s;
  logic [2:0] rgb_in_s;
  logic       boundary_s, match_s, acc_upd_s, take_snap_s;

  assign x_in_s      = RGBStr_i[`XC];
  assign y_in_s      = RGBStr_i[`YC];
  assign rgb_in_s    = RGBStr_i[`RGB];
  assign boundary_s  = (y_in_s < prev_yc_q);
  assign match_s     = (rgb_in_s == MATCH_RGB) && ({1'b0, x_in_s} < H_LIM) && ({1'b0, y_in_s} < V_LIM);
  assign acc_upd_s   = match_s && ((state_q != SYNC) || boundary_s);
  assign take_snap_s = boundary_s && (state_q != SYNC);

  // Accumulators restart on a boundary and then absorb the boundary pixel, so it lands in the new frame.
  always_comb begin
    min_x_d = boundary_s ? MIN_CLR : min_x_q;
    min_y_d = boundary_s ? MIN_CLR : min_y_q;
    cnt_d   = boundary_s ? 19'd0   : cnt_q;
    min_x_d = acc_upd_s ? lower(x_in_s, min_x_d) : min_x_d;
    min_y_d = acc_upd_s ? lower(y_in_s, min_y_d) : min_y_d;
    cnt_d   = acc_upd_s ? sat_inc(cnt_d) : cnt_d;
    snap_min_x_d = take_snap_s ? min_x_q : snap_min_x_q;
    snap_min_y_d = take_snap_s ? min_y_q : snap_min_y_q;
    snap_cnt_d   = take_snap_s ? cnt_q   : snap_cnt_q;
`ifdef PXS_BALL_FINDER_CENTER_EN
    max_x_d = boundary_s ? MAX_CLR : max_x_q;
    max_y_d = boundary_s ? MAX_CLR : max_y_q;
    max_x_d = acc_upd_s ? upper(x_in_s, max_x_d) : max_x_d;
    max_y_d = acc_upd_s ? upper(y_in_s, max_y_d) : max_y_d;
    snap_max_x_d = take_snap_s ? max_x_q : snap_max_x_q;
    snap_max_y_d = take_snap_s ? max_y_q : snap_max_y_q;
`endif
  end

  // Frame FSM next state and result commit.
  always_comb begin
    state_d      = state_q;
    found_d      = found_q;
    x_ball_d     = x_ball_q;
    y_ball_d     = y_ball_q;
    frame_done_d = 1'b0;
    case (state_q)
      SYNC: begin
        state_d = boundary_s ? SCAN : SYNC;
      end
      SCAN: begin
        state_d = boundary_s ? COMMIT : SCAN;
      end
      COMMIT: begin
        state_d      = boundary_s ? COMMIT : SCAN;
        frame_done_d = 1'b1;
        found_d      = (snap_cnt_q >= MIN_LIM);
        if (snap_cnt_q >= MIN_LIM) begin
`ifdef PXS_BALL_FINDER_CENTER_EN
          x_ball_d = ball_coord(snap_min_x_q, snap_max_x_q);
          y_ball_d = ball_coord(snap_min_y_q, snap_max_y_q);
`else
          x_ball_d = ball_coord(snap_min_x_q);
          y_ball_d = ball_coord(snap_min_y_q);
`endif
        end else begin
          x_ball_d = x_ball_q;
          y_ball_d = y_ball_q;
        end
      end
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  // State, accumulator, snapshot and output registers.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SYNC;
      rgbstr_q     <= 26'd0;
      prev_yc_q    <= 10'd0;
      min_x_q      <= MIN_CLR;
      min_y_q      <= MIN_CLR;
      cnt_q        <= 19'd0;
      snap_min_x_q <= MIN_CLR;
      snap_min_y_q <= MIN_CLR;
      snap_cnt_q   <= 19'd0;
      x_ball_q     <= 10'd0;
      y_ball_q     <= 10'd0;
      found_q      <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PXS_BALL_FINDER_CENTER_EN
      max_x_q      <= MAX_CLR;
      max_y_q      <= MAX_CLR;
      snap_max_x_q <= MAX_CLR;
      snap_max_y_q <= MAX_CLR;
`endif
    end else begin
      state_q      <= state_d;
      rgbstr_q     <= RGBStr_i;
      prev_yc_q    <= y_in_s;
      min_x_q      <= min_x_d;
      min_y_q      <= min_y_d;
      cnt_q        <= cnt_d;
      snap_min_x_q <= snap_min_x_d;
      snap_min_y_q <= snap_min_y_d;
      snap_cnt_q   <= snap_cnt_d;
      x_ball_q     <= x_ball_d;
      y_ball_q     <= y_ball_d;
      found_q      <= found_d;
      frame_done_q <= frame_done_d;
`ifdef PXS_BALL_FINDER_CENTER_EN
      max_x_q      <= max_x_d;
      max_y_q      <= max_y_d;
      snap_max_x_q <= snap_max_x_d;
      snap_max_y_q <= snap_max_y_d;
`endif
    end
  end

  assign RGBStr_o   = rgbstr_q;
  assign x_ball     = x_ball_q;
  assign y_ball     = y_ball_q;
  assign found      = found_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pxs_ball_finder.sv
// Directed bench for pxs_ball_finder: per-frame results scoreboarded, passthrough checked every cycle.
module tb_pxs_ball_finder;

  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] BLACK = 3'b000;

  logic        px_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [25:0] RGBStr_i = 26'd0;
  logic [25:0] RGBStr_o;
  logic [9:0]  x_ball, y_ball;
  logic        found, frame_done;

  pxs_ball_finder dut (
    .px_clk(px_clk), .rst_n(rst_n), .RGBStr_i(RGBStr_i), .RGBStr_o(RGBStr_o),
    .x_ball(x_ball), .y_ball(y_ball), .found(found), .frame_done(frame_done)
  );

  always #5 px_clk = ~px_clk;

  typedef struct {
    int         cyc;
    logic       f;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          sb_en = 1'b0;
  logic [9:0]  hold_x = 10'd0;
  logic [9:0]  hold_y = 10'd0;
  logic [25:0] exp_pt = 26'd0;

  always @(posedge px_clk) cyc <= cyc + 1;

  always @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) exp_pt <= 26'd0;
    else        exp_pt <= RGBStr_i;
  end

  function automatic logic [25:0] pack(input logic [9:0] x, input logic [9:0] y, input logic [2:0] rgb);
    return {3'b000, x, y, rgb};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_px(input logic [9:0] x, input logic [9:0] y, input logic [2:0] rgb);
    RGBStr_i = pack(x, y, rgb);
    @(posedge px_clk);
    #1;
  endtask

  // Wrap pixel ends the frame; expected report is due one edge after the wrap edge.
  task automatic frame_end(input logic [2:0] wrgb, input logic f, input logic [9:0] mnx, input logic [9:0] mny,
                           input logic [9:0] mxx, input logic [9:0] mxy);
    exp_t e;
    send_px(10'd0, 10'd0, wrgb);
    if (f) begin
`ifdef PXS_BALL_FINDER_CENTER_EN
      hold_x = 10'((11'(mnx) + 11'(mxx)) >> 1);
      hold_y = 10'((11'(mny) + 11'(mxy)) >> 1);
`else
      hold_x = (mnx == 10'd0) ? 10'd0 : mnx - 10'd1;
      hold_y = (mny == 10'd0) ? 10'd0 : mny - 10'd1;
`endif
    end
    e.cyc = cyc + 1;
    e.f   = f;
    e.x   = hold_x;
    e.y   = hold_y;
    q.push_back(e);
  endtask

  task automatic send_square();
    for (int y = 50; y <= 67; y++) begin
      for (int x = 100; x <= 117; x++) begin
        send_px(10'(x), 10'(y), (x >= 101 && x <= 116 && y >= 51 && y <= 66) ? WHITE : BLACK);
      end
    end
  endtask

  always @(negedge px_clk) begin
    if (mon_en) begin
      check("passthrough", 32'(RGBStr_o), 32'(exp_pt));
      if (sb_en && frame_done === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'(frame_done), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          check("found", 32'(found), 32'(e.f));
          check("x_ball", 32'(x_ball), 32'(e.x));
          check("y_ball", 32'(y_ball), 32'(e.y));
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge px_clk);
    #1;
    check("rst_rgbstr", 32'(RGBStr_o), 32'd0);
    check("rst_x", 32'(x_ball), 32'd0);
    check("rst_y", 32'(y_ball), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    sb_en  = 1'b1;

    // Partial first frame: only brings the FSM out of SYNC, never reported.
    for (int i = 0; i < 4; i++) send_px(10'(i), 10'(i), WHITE);
    send_px(10'd0, 10'd0, BLACK);

    send_square();
    frame_end(BLACK, 1'b1, 10'd101, 10'd51, 10'd116, 10'd66);

    // Three matches only: below threshold, coordinates hold.
    for (int i = 10; i < 13; i++) send_px(10'(i), 10'd10, WHITE);
    send_px(10'd13, 10'd10, BLACK);
    frame_end(WHITE, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0);

    // The white wrap pixel above belongs to this frame.
    for (int i = 5; i < 8; i++) send_px(10'(i), 10'd5, WHITE);
    frame_end(BLACK, 1'b1, 10'd0, 10'd0, 10'd7, 10'd5);

    // Matches outside the active window only.
    for (int i = 700; i < 704; i++) send_px(10'(i), 10'd10, WHITE);
    send_px(10'd10, 10'd490, WHITE);
    frame_end(BLACK, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0);

    send_square();
    frame_end(BLACK, 1'b1, 10'd101, 10'd51, 10'd116, 10'd66);

    // Reset in the middle of row 200.
    send_px(10'd0, 10'd100, BLACK);
    for (int i = 0; i < 5; i++) send_px(10'(i), 10'd200, BLACK);
    check("pre_rst_found", 32'(found), 32'd1);
    check("pre_rst_x", 32'(x_ball), 32'(hold_x));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_x", 32'(x_ball), 32'd0);
    check("mid_rst_y", 32'(y_ball), 32'd0);
    check("mid_rst_found", 32'(found), 32'd0);
    check("mid_rst_done", 32'(frame_done), 32'd0);
    check("mid_rst_rgbstr", 32'(RGBStr_o), 32'd0);
    hold_x = 10'd0;
    hold_y = 10'd0;
    @(posedge px_clk);
    @(posedge px_clk);
    #1;
    rst_n = 1'b1;
    for (int i = 5; i < 10; i++) send_px(10'(i), 10'd200, BLACK);
    send_px(10'd0, 10'd300, BLACK);
    send_px(10'd0, 10'd0, BLACK);
    send_square();
    frame_end(BLACK, 1'b1, 10'd101, 10'd51, 10'd116, 10'd66);
    for (int i = 1; i < 5; i++) send_px(10'(i), 10'd0, BLACK);
    check("pending_reports", 32'(q.size()), 32'd0);

    // Random stream: only the one-cycle passthrough is checked.
    sb_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      RGBStr_i = 26'($urandom);
      @(posedge px_clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
